// File: rtl/arbitro_mux.sv
// arbitro_mux: registered N-way request arbiter and data mux.
// Fixed-priority or round-robin winner, valid/ack hold semantics.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous, active-high; clears all state
//   m       - mode: 0 fixed priority (ch 0 highest), 1 round-robin
//   req     - per-channel request, bit i = channel i
//   data_in - packed channel data, ch i at [i*W +: W]
//   ack     - consumer takes the current output while valid=1
//   y       - registered data of the granted channel
//   valid   - y/grant/gidx hold a live grant
//   grant   - one-hot grant, zero when idle
//   gidx    - index of the granted channel
module arbitro_mux #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 m,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data_in,
  input  logic                 ack,
  output logic [W-1:0]         y,
  output logic                 valid,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] gidx
);

  localparam int PW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [W-1:0]    y_q;
  logic [W-1:0]    y_d;
  logic [N-1:0]    grant_q;
  logic [N-1:0]    grant_d;
  logic [PW-1:0]   gidx_q;
  logic [PW-1:0]   gidx_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;

  logic            arb;
  logic            any_req;
  logic [PW-1:0]   fp_idx;
  logic [PW-1:0]   rr_idx;
  logic [PW-1:0]   win;

  // (a + k) mod N for k < N; keeps ptr below N
  // even when N is not a power of two.
  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] a,
    input int            k
  );
    int s;
    s = int'(a) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  assign any_req = |req;

  // Fixed priority: walk downward so the lowest
  // asserted index is the last one written.
  always_comb begin
    fp_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) fp_idx = PW'(i);
    end
  end

  // Round-robin: same trick over the rotated order
  // ptr, ptr+1, ... so the smallest offset wins.
  always_comb begin
    logic [PW-1:0] c;
    rr_idx = '0;
    c      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = wrap_add(ptr_q, k);
      if (req[c]) rr_idx = c;
    end
  end

  assign win = m ? rr_idx : fp_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    arb     = 1'b0;

    unique case (state_q)
      IDLE:    arb = 1'b1;
      GRANT:   arb = ack;
      default: arb = 1'b1;
    endcase

    if (arb) begin
      if (any_req) begin
        state_d      = GRANT;
        gidx_d       = win;
        grant_d      = '0;
        grant_d[win] = 1'b1;
        y_d          = data_in[int'(win)*W +: W];
        if (m) ptr_d = wrap_add(win, 1);
      end else begin
        state_d = IDLE;
        y_d     = '0;
        grant_d = '0;
        gidx_d  = '0;
      end
    end
  end

  assign y     = y_q;
  assign valid = (state_q == GRANT);
  assign grant = grant_q;
  assign gidx  = gidx_q;

endmodule

// File: tb/tb_arbitro_mux.sv
// tb_arbitro_mux: directed + random checks of arbitro_mux
// against a scan-order reference model (N=4, W=8).
module tb_arbitro_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         m = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] data_in = '0;
  logic         ack = 1'b0;
  logic [W-1:0] y;
  logic         valid;
  logic [N-1:0] grant;
  logic [1:0]   gidx;

  int errors = 0;
  int checks = 0;

  // reference model state
  int           r_ptr = 0;
  logic         e_valid = 1'b0;
  logic [N-1:0] e_grant = '0;
  logic [1:0]   e_gidx = '0;
  logic [W-1:0] e_y = '0;

  arbitro_mux #(.N(N), .W(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .m       (m),
    .req     (req),
    .data_in (data_in),
    .ack     (ack),
    .y       (y),
    .valid   (valid),
    .grant   (grant),
    .gidx    (gidx)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    r_ptr   = 0;
    e_valid = 1'b0;
    e_grant = '0;
    e_gidx  = '0;
    e_y     = '0;
  endtask

  // One rising edge; model consumes the inputs seen
  // at that edge, outputs are sampled 1 time unit later.
  task automatic step();
    int start;
    int w;
    @(posedge clock);
    if (!e_valid || ack) begin
      if (req == '0) begin
        e_valid = 1'b0;
        e_grant = '0;
        e_gidx  = '0;
        e_y     = '0;
      end else begin
        start = m ? r_ptr : 0;
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(start + k) % N]) w = (start + k) % N;
        e_valid = 1'b1;
        e_grant = 4'(1 << w);
        e_gidx  = 2'(w);
        e_y     = data_in[w*W +: W];
        if (m) r_ptr = (w + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b1111;
    ack = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({valid, grant, gidx, y} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b g=%b i=%0d y=%h want all 0",
               valid, grant, gidx, y);
    end
    reset = 1'b0;
    model_reset();
    req = '0;
    ack = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL idle_ack: got v=%b g=%b want v=0 g=0",
               valid, grant);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    m = 1'b0;
    ack = 1'b0;
    req = 4'b1010;
    data_in = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    step();
    checks++;
    if ({valid, grant, gidx, y} !== {1'b1, 4'b0010, 2'd1, 8'hBB}) begin
      errors++;
      $display("FAIL fixed_first: got v=%b g=%b i=%0d y=%h want 1 0010 1 bb",
               valid, grant, gidx, y);
    end
  endtask

  task automatic test_hold();
    ack = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      data_in = {8'h11, 8'h22, 8'h33, 8'(c)};
      m = c[0];
      step();
      checks++;
      if ({valid, grant, y} !== {1'b1, 4'b0010, 8'hBB}) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b g=%b y=%h want 1 0010 bb",
                 c, valid, grant, y);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    m = 1'b1;
    ack = 1'b1;
    req = 4'b1111;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (valid !== 1'b1 || gidx !== 2'(exp_seq[c])
          || y !== 8'(8'h11 * (exp_seq[c] + 1))) begin
        errors++;
        $display("FAIL rr_seq_%0d: got v=%b i=%0d y=%h want 1 %0d",
                 c, valid, gidx, y, exp_seq[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    m = 1'b1;
    ack = 1'b1;
    req = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (valid !== 1'b1 || gidx !== (c[0] ? 2'd3 : 2'd0)) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b i=%0d want v=1 i=%0d",
                 c, valid, gidx, c[0] ? 3 : 0);
      end
    end
  endtask

  task automatic test_empty();
    ack = 1'b1;
    req = '0;
    step();
    checks++;
    if ({valid, grant, y} !== '0) begin
      errors++;
      $display("FAIL empty: got v=%b g=%b y=%h want 0 0 0",
               valid, grant, y);
    end
    step();
    req = 4'b0100;
    step();
    checks++;
    if (valid !== 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL empty_regrant: got v=%b g=%b want 1 0100",
               valid, grant);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    m = 1'b1;
    ack = 1'b0;
    req = 4'b0010;
    data_in = {8'h9D, 8'h9C, 8'h9B, 8'h9A};
    step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({valid, grant, gidx, y} !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b g=%b i=%0d y=%h want all 0",
               valid, grant, gidx, y);
    end
    #1 reset = 1'b0;
    model_reset();
    req = 4'b1111;
    step();
    checks++;
    if (valid !== 1'b1 || gidx !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_rr: got v=%b i=%0d want 1 0",
               valid, gidx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      m = 1'($urandom_range(0, 1));
      ack = ($urandom_range(0, 3) != 0);
      req = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom);
      data_in = $urandom;
      step();
      checks++;
      if ({valid, grant, gidx, y} !== {e_valid, e_grant, e_gidx, e_y}) begin
        errors++;
        $display("FAIL rand_%0d: got v=%b g=%b i=%0d y=%h want v=%b g=%b i=%0d y=%h",
                 c, valid, grant, gidx, y, e_valid, e_grant, e_gidx, e_y);
      end
      checks++;
      if (grant !== '0 && (grant & (grant - 1'b1)) !== '0) begin
        errors++;
        $display("FAIL onehot_%0d: got g=%b want one-hot", c, grant);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_hold();
    test_round_robin();
    test_back_to_back();
    test_empty();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arbitro_mux.md
ARBITRO_MUX -- requirements
Module: arbitro_mux

Interface
REQ-001 Parameter N, default 4: number of request/data channels, legal range 2..16.
REQ-002 Parameter W, default 1: data width per channel, legal range 1..32.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-005 m  input  1  mode: 0 = fixed priority, channel 0 highest; 1 = round-robin.
REQ-006 req  input  N  request per channel, bit i = channel i.
REQ-007 data_in  input  N*W  channel i data at bits [i*W+W-1 : i*W].
REQ-008 ack  input  1  consumer accepts the current output while valid=1.
REQ-009 y  output  W  registered data of the granted channel.
REQ-010 valid  output  1  y, grant and gidx hold a live grant.
REQ-011 grant  output  N  one-hot grant; all zeros when valid=0.
REQ-012 gidx  output  $clog2(N)  index of the granted channel.

Function
REQ-013 Two-state machine: IDLE (valid=0) and GRANT (valid=1).
REQ-014 Arbitration happens only on a rising edge where (state=IDLE) or (state=GRANT and ack=1); the result appears in the registers at that edge, one cycle after sampling.
REQ-015 Arbitration with req=0: next state IDLE; grant=0, gidx=0, y=0.
REQ-016 Arbitration with req!=0: next state GRANT; winner registered into grant/gidx; data_in slice of the winner latched into y.
REQ-017 m=0: winner is the lowest-index asserted req bit; round-robin pointer ptr is unchanged.
REQ-018 m=1: winner is the first asserted req bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-019 Every grant issued with m=1 sets ptr to (winner+1) mod N, wrapping N-1 -> 0.
REQ-020 m is sampled only at arbitration edges; changing m during GRANT has no effect on the held grant.
REQ-021 In GRANT with ack=0: y, grant, gidx and valid hold; changes on req or data_in are ignored, including deassertion of the granted req.
REQ-022 ack=1 in GRANT with any req set: new arbitration at that edge, back-to-back, with no idle cycle; the same channel may win again if rules allow.
REQ-023 ack while in IDLE is ignored.
REQ-024 ptr has width $clog2(N); with N not a power of two, ptr never holds a value >= N.
REQ-025 grant is always one-hot or zero; valid=1 iff grant!=0.

Reset
REQ-026 reset=1 forces state=IDLE, valid=0, grant=0, gidx=0, y=0 and ptr=0 asynchronously.
REQ-027 reset asserted during GRANT discards the grant without waiting for ack.
REQ-028 The first rising edge after reset deasserts performs an arbitration per REQ-014.

Verification (N=4, W=8)
REQ-029 Reset released; m=0; req=4'b1010; data_in={8'hDD,8'hCC,8'hBB,8'hAA} -> next edge: valid=1, grant=4'b0010, gidx=1, y=8'hBB.
REQ-030 Hold: in GRANT for gidx=1, ack=0 for 3 cycles, req changed to 4'b0001, data_in changed -> y=8'hBB, grant=4'b0010 unchanged throughout.
REQ-031 Round-robin: m=1, ptr=0, req=4'b1111 held, ack=1 every cycle -> gidx sequence 0,1,2,3,0; check the wrap 3 -> 0.
REQ-032 Back-to-back: m=1, req=4'b1001, ack=1 continuously -> gidx alternates 0,3,0,3 with valid continuously 1.
REQ-033 Empty: in GRANT, ack=1 with req=0 -> next edge valid=0, grant=0, y=0; later req=4'b0100 -> grant=4'b0100 one edge after.
REQ-034 Async reset: in GRANT with ptr=2, pulse reset between edges -> valid, grant, gidx, y drop to 0 before the next edge; the next m=1 arbitration with req=4'b1111 grants gidx=0.
